// File: rtl/mcp_temp_proc.sv
// mcp_temp_proc: block-average ADC samples, scale to degC,
// convert to BCD and drive an over-temperature LED with hysteresis.
module mcp_temp_proc #(
  parameter int SAMPLE_W    = 8,
  parameter int AVG_LOG2    = 3,
  parameter int SCALE_MUL   = 165,
  parameter int SCALE_SHIFT = 7,
  parameter int HOT_ON      = 40,
  parameter int HOT_OFF     = 37
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] sample,
  output logic                busy,
  output logic [8:0]          temp_c,
  output logic [3:0]          bcd2,
  output logic [3:0]          bcd1,
  output logic [3:0]          bcd0,
  output logic                temp_valid,
  output logic                overrun,
  output logic                led
);

  localparam int SUM_W  = SAMPLE_W + AVG_LOG2;
  localparam int PROD_W = SAMPLE_W + 8;
  localparam int DD_W   = 21;

  typedef enum logic [1:0] {
    IDLE,
    SCALE,
    BCD,
    DONE
  } state_t;

  state_t              state;
  logic [SUM_W-1:0]    sum;
  logic [SUM_W-1:0]    sum_next;
  logic [AVG_LOG2-1:0] cnt;
  logic                blk_done;
  logic [SAMPLE_W-1:0] blk_avg;
  logic [SAMPLE_W-1:0] avg_q;
  logic [PROD_W-1:0]   prod;
  logic [8:0]          temp_scaled;
  logic [8:0]          temp_bin;
  logic [DD_W-1:0]     dd_q;
  logic [DD_W-1:0]     dd_adj;
  logic [DD_W-1:0]     dd_shift;
  logic [3:0]          bit_cnt;

  assign sum_next    = sum + SUM_W'(sample);
  assign blk_done    = sample_valid && (&cnt);
  assign blk_avg     = SAMPLE_W'(sum_next >> AVG_LOG2);
  assign prod        = PROD_W'(avg_q) * PROD_W'(SCALE_MUL);
  assign temp_scaled = 9'(prod >> SCALE_SHIFT);

  // Double-dabble step: digits >= 5 get +3, then shift left.
  // Layout: [20:17] hundreds, [16:13] tens, [12:9] units, [8:0] binary.
  always_comb begin
    dd_adj = dd_q;
    for (int i = 0; i < 3; i++) begin
      if (dd_q[9+4*i +: 4] >= 4'd5)
        dd_adj[9+4*i +: 4] = dd_q[9+4*i +: 4] + 4'd3;
    end
    dd_shift = {dd_adj[DD_W-2:0], 1'b0};
  end

  // Free-running block accumulator, restarts on each completed block.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum <= '0;
      cnt <= '0;
    end else if (sample_valid) begin
      if (&cnt) begin
        sum <= '0;
        cnt <= '0;
      end else begin
        sum <= sum_next;
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Conversion FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      temp_valid <= 1'b0;
      overrun    <= 1'b0;
      led        <= 1'b0;
      temp_c     <= '0;
      bcd2       <= '0;
      bcd1       <= '0;
      bcd0       <= '0;
      avg_q      <= '0;
      temp_bin   <= '0;
      dd_q       <= '0;
      bit_cnt    <= '0;
    end else begin
      temp_valid <= 1'b0;
      if (blk_done && state != IDLE)
        overrun <= 1'b1;
      unique case (state)
        IDLE: begin
          if (blk_done) begin
            avg_q <= blk_avg;
            busy  <= 1'b1;
            state <= SCALE;
          end
        end
        SCALE: begin
          temp_bin <= temp_scaled;
          dd_q     <= {12'd0, temp_scaled};
          bit_cnt  <= 4'd9;
          state    <= BCD;
        end
        BCD: begin
          dd_q    <= dd_shift;
          bit_cnt <= bit_cnt - 1'b1;
          if (bit_cnt == 4'd1) begin
            state      <= DONE;
            temp_valid <= 1'b1;
            temp_c     <= temp_bin;
            bcd2       <= dd_shift[20:17];
            bcd1       <= dd_shift[16:13];
            bcd0       <= dd_shift[12:9];
            if (temp_bin >= 9'(HOT_ON))
              led <= 1'b1;
            else if (temp_bin <= 9'(HOT_OFF))
              led <= 1'b0;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mcp_temp_proc.sv
// tb_mcp_temp_proc: scenario tasks checked against an
// arithmetic reference of averaging, scaling, BCD and hysteresis.
module tb_mcp_temp_proc;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sample_valid = 1'b0;
  logic [7:0] sample = '0;
  logic       busy;
  logic [8:0] temp_c;
  logic [3:0] bcd2, bcd1, bcd0;
  logic       temp_valid;
  logic       overrun;
  logic       led;

  int errors = 0;
  int checks = 0;
  int model_led = 0;

  mcp_temp_proc dut (
    .clk(clk),
    .rst(rst),
    .sample_valid(sample_valid),
    .sample(sample),
    .busy(busy),
    .temp_c(temp_c),
    .bcd2(bcd2),
    .bcd1(bcd1),
    .bcd0(bcd0),
    .temp_valid(temp_valid),
    .overrun(overrun),
    .led(led)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int v);
    sample_valid = 1'b1;
    sample = 8'(v);
    step();
    sample_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sample_valid = 1'b0;
    step();
    rst = 1'b0;
    model_led = 0;
  endtask

  function automatic int ref_temp(input int s[8]);
    int total = 0;
    foreach (s[i]) total += s[i];
    return ((total / 8) * 165) / 128;
  endfunction

  function automatic int ref_led(input int t, input int prev);
    if (t >= 40) return 1;
    if (t <= 37) return 0;
    return prev;
  endfunction

  function automatic logic [20:0] ref_digits(input int t);
    return {9'(t), 4'(t / 100), 4'((t / 10) % 10), 4'(t % 10)};
  endfunction

  // Feeds one block; lat counts cycles from the last sample to temp_valid
  // (capped at 40), b1 is busy in the first cycle after it.
  task automatic run_block(input int s[8], input int gap,
                           output int lat, output logic b1);
    for (int i = 0; i < 8; i++) begin
      send(s[i]);
      if (i < 7) repeat (gap) step();
    end
    b1 = busy;
    lat = 1;
    while (temp_valid !== 1'b1 && lat < 40) begin
      step();
      lat++;
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({temp_c, bcd2, bcd1, bcd0} !== 21'd0) begin
      errors++;
      $display("FAIL reset_data got %h want 0", {temp_c, bcd2, bcd1, bcd0});
    end
    checks++;
    if ({temp_valid, busy, overrun, led} !== 4'b0) begin
      errors++;
      $display("FAIL reset_flags got %b want 0000",
               {temp_valid, busy, overrun, led});
    end
  endtask

  task automatic test_basic();
    int s[8];
    int lat, t;
    logic b1;
    foreach (s[i]) s[i] = 100;
    t = ref_temp(s);
    model_led = ref_led(t, model_led);
    run_block(s, 19, lat, b1);
    checks++;
    if (lat !== 11) begin
      errors++;
      $display("FAIL basic_latency got %0d want 11", lat);
    end
    checks++;
    if (b1 !== 1'b1) begin
      errors++;
      $display("FAIL basic_busy got %b want 1", b1);
    end
    checks++;
    if ({temp_c, bcd2, bcd1, bcd0} !== ref_digits(t) || t != 128) begin
      errors++;
      $display("FAIL basic_value got %0d %0d%0d%0d want 128 128",
               temp_c, bcd2, bcd1, bcd0);
    end
    checks++;
    if (led !== 1'(model_led) || overrun !== 1'b0) begin
      errors++;
      $display("FAIL basic_led_ovr got %b%b want %0d0", led, overrun, model_led);
    end
    step();
    checks++;
    if (temp_valid !== 1'b0 || temp_c !== 9'(t)) begin
      errors++;
      $display("FAIL basic_pulse got v=%b t=%0d want v=0 t=%0d",
               temp_valid, temp_c, t);
    end
  endtask

  task automatic test_full_scale();
    int s[8];
    int lat, t;
    logic b1;
    foreach (s[i]) s[i] = 255;
    t = ref_temp(s);
    model_led = ref_led(t, model_led);
    run_block(s, 2, lat, b1);
    checks++;
    if (lat !== 11 || {temp_c, bcd2, bcd1, bcd0} !== ref_digits(t)) begin
      errors++;
      $display("FAIL full_scale got lat=%0d t=%0d %0d%0d%0d want 11 %0d",
               lat, temp_c, bcd2, bcd1, bcd0, t);
    end
    foreach (s[i]) s[i] = 0;
    s[7] = 7;
    t = ref_temp(s);
    model_led = ref_led(t, model_led);
    run_block(s, 1, lat, b1);
    checks++;
    if (lat !== 11 || {temp_c, bcd2, bcd1, bcd0} !== ref_digits(t)
        || led !== 1'(model_led)) begin
      errors++;
      $display("FAIL truncate got lat=%0d t=%0d led=%b want 11 %0d %0d",
               lat, temp_c, led, t, model_led);
    end
  endtask

  task automatic test_hysteresis();
    int vals[4] = '{31, 32, 31, 29};
    int s[8];
    int lat, t;
    logic b1;
    foreach (vals[k]) begin
      foreach (s[i]) s[i] = vals[k];
      t = ref_temp(s);
      model_led = ref_led(t, model_led);
      run_block(s, 3, lat, b1);
      checks++;
      if (lat !== 11 || temp_c !== 9'(t) || led !== 1'(model_led)) begin
        errors++;
        $display("FAIL hyst_%0d got lat=%0d t=%0d led=%b want 11 %0d %0d",
                 vals[k], lat, temp_c, led, t, model_led);
      end
    end
  endtask

  task automatic test_overrun();
    int pulses = 0;
    int first = -1;
    int second = -1;
    do_reset();
    for (int k = 0; k < 60; k++) begin
      sample_valid = (k < 24);
      sample = 8'd100;
      step();
      if (temp_valid === 1'b1) begin
        pulses++;
        if (first < 0) first = k;
        else if (second < 0) second = k;
      end
    end
    sample_valid = 1'b0;
    checks++;
    if (pulses !== 2 || first !== 17 || second !== 33) begin
      errors++;
      $display("FAIL overrun_pulses got n=%0d at %0d,%0d want 2 at 17,33",
               pulses, first, second);
    end
    checks++;
    if (overrun !== 1'b1 || temp_c !== 9'd128) begin
      errors++;
      $display("FAIL overrun_flag got o=%b t=%0d want 1 128", overrun, temp_c);
    end
    repeat (20) step();
    checks++;
    if (overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_sticky got %b want 1", overrun);
    end
    do_reset();
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL overrun_clear got %b want 0", overrun);
    end
  endtask

  // Completing samples 11 cycles apart lands in DONE; 12 apart is clean.
  task automatic test_spacing();
    int pulses;
    for (int idle = 3; idle <= 4; idle++) begin
      do_reset();
      pulses = 0;
      for (int k = 0; k < 50; k++) begin
        sample_valid = (k < 8) || (k >= 8 + idle && k < 16 + idle);
        sample = 8'd60;
        step();
        if (temp_valid === 1'b1) pulses++;
      end
      sample_valid = 1'b0;
      checks++;
      if (overrun !== 1'(idle == 3) || pulses !== (idle == 3 ? 1 : 2)) begin
        errors++;
        $display("FAIL spacing_%0d got o=%b n=%0d want o=%0d n=%0d",
                 idle + 8, overrun, pulses, idle == 3, idle == 3 ? 1 : 2);
      end
    end
  endtask

  task automatic test_back_to_back();
    int s[8];
    int lat, t;
    logic b1;
    do_reset();
    foreach (s[i]) s[i] = 100;
    run_block(s, 0, lat, b1);
    foreach (s[i]) s[i] = 0;
    s[0] = 255;
    t = ref_temp(s);
    run_block(s, 0, lat, b1);
    checks++;
    if (lat !== 11 || temp_c !== 9'(t) || overrun !== 1'b0) begin
      errors++;
      $display("FAIL back_to_back got lat=%0d t=%0d o=%b want 11 %0d 0",
               lat, temp_c, overrun, t);
    end
  endtask

  task automatic test_reset_mid();
    int s[8];
    int lat, t, seen;
    logic b1;
    for (int i = 0; i < 8; i++) send(100);
    repeat (4) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    model_led = 0;
    checks++;
    if ({temp_c, bcd2, bcd1, bcd0, temp_valid, busy, overrun, led} !== 25'd0)
    begin
      errors++;
      $display("FAIL reset_mid got t=%0d v=%b b=%b led=%b want all 0",
               temp_c, temp_valid, busy, led);
    end
    seen = 0;
    repeat (15) begin
      step();
      if (temp_valid === 1'b1) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL reset_mid_valid got %0d pulses want 0", seen);
    end
    foreach (s[i]) s[i] = 24;
    t = ref_temp(s);
    model_led = ref_led(t, model_led);
    run_block(s, 1, lat, b1);
    checks++;
    if (lat !== 11 || {temp_c, bcd2, bcd1, bcd0} !== ref_digits(t)
        || led !== 1'(model_led)) begin
      errors++;
      $display("FAIL after_reset got lat=%0d t=%0d led=%b want 11 %0d %0d",
               lat, temp_c, led, t, model_led);
    end
  endtask

  task automatic test_partial();
    int s[8];
    int lat, t;
    logic b1;
    for (int i = 0; i < 5; i++) send(200);
    do_reset();
    foreach (s[i]) s[i] = 50;
    t = ref_temp(s);
    run_block(s, 0, lat, b1);
    checks++;
    if (lat !== 11 || temp_c !== 9'(t)) begin
      errors++;
      $display("FAIL partial got lat=%0d t=%0d want 11 %0d", lat, temp_c, t);
    end
  endtask

  task automatic test_random();
    int s[8];
    int lat, t;
    logic b1;
    do_reset();
    for (int b = 0; b < 10; b++) begin
      foreach (s[i]) s[i] = $urandom_range(0, 255);
      t = ref_temp(s);
      model_led = ref_led(t, model_led);
      run_block(s, $urandom_range(0, 3), lat, b1);
      checks++;
      if (lat !== 11 || {temp_c, bcd2, bcd1, bcd0} !== ref_digits(t)
          || led !== 1'(model_led) || overrun !== 1'b0) begin
        errors++;
        $display("FAIL random_%0d got lat=%0d t=%0d %0d%0d%0d led=%b want %0d %0d",
                 b, lat, temp_c, bcd2, bcd1, bcd0, led, t, model_led);
      end
      repeat ($urandom_range(0, 5)) step();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full_scale();
    test_hysteresis();
    test_overrun();
    test_spacing();
    test_back_to_back();
    test_reset_mid();
    test_partial();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mcp_temp_proc.md
# mcp_temp_proc

Downstream stage of the MCP ADC SPI reader. It takes each 8-bit ADC sample, averages blocks of 2^AVG_LOG2 samples, and scales the average to whole degrees Celsius. It then converts the result to three BCD digits for the seven-segment display and drives the over-temperature LED with hysteresis.

## Interface
- SAMPLE_W, 8, ADC sample width
- AVG_LOG2, 3, log2 of the averaging block length (8 samples)
- SCALE_MUL, 165, 8-bit unsigned scale multiplier
- SCALE_SHIFT, 7, right shift after multiply (165/128 ≈ 1.289 °C/LSB: 3.3 V/256 with a 10 mV/°C sensor)
- HOT_ON, 40, LED set threshold, °C
- HOT_OFF, 37, LED clear threshold, °C
- clk  in  1  system clock; everything is on the rising edge
- rst  in  1  synchronous, active-high reset
- sample_valid  in  1  one-cycle strobe; sample is accepted on any edge where this is high
- sample  in  SAMPLE_W  ADC result from the SPI reader
- busy  out  1  high while a conversion is in progress (state != IDLE)
- temp_c  out  9  temperature in whole °C, unsigned
- bcd2, bcd1, bcd0  out  4 each  hundreds, tens and units digits of temp_c
- temp_valid  out  1  one-cycle pulse when outputs update
- overrun  out  1  sticky flag: a completed average was dropped
- led  out  1  over-temperature indicator

## Operation
- **Accumulator.** Runs independently of the FSM.
  - Sum width is SAMPLE_W+AVG_LOG2; the sample counter is AVG_LOG2 bits.
  - Each accepted sample adds to the sum and increments the counter.
  - When the counter wraps (the 2^AVG_LOG2-th sample), a block completes: avg = (sum + sample) >> AVG_LOG2, truncating. Sum and counter restart from 0 on the same edge.
- **Block completes while FSM is IDLE.** avg is latched and the FSM goes to SCALE.
- **Block completes while busy, including the DONE cycle.** The average is discarded, overrun is set to 1 and stays 1 until rst, and accumulation continues.
- **FSM states:**
  - IDLE: wait for a completed block.
  - SCALE: one edge. temp_bin = (avg * SCALE_MUL) >> SCALE_SHIFT. The product is SAMPLE_W+8 bits; the result is truncated to 9 bits (max 328 at the defaults). The BCD shift counter is loaded with 9.
  - BCD: double-dabble, one bit per edge, for 9 edges. Before each shift, add 3 to any digit ≥ 5.
  - DONE: one cycle, then back to IDLE.
- **On entry to DONE (registered):**
  - temp_c, bcd2, bcd1 and bcd0 are updated.
  - temp_valid = 1 for this cycle only.
  - LED hysteresis: if temp_c ≥ HOT_ON then led = 1; else if temp_c ≤ HOT_OFF then led = 0; otherwise led holds its value.
- **Output hold.** temp_c, the BCD digits and led hold their values between updates.
- **Reset.** temp_c = 0, all BCD digits = 0, temp_valid = 0, busy = 0, overrun = 0, led = 0, sum and counter = 0, FSM = IDLE.
- **Reset mid-conversion.** The conversion is aborted, no temp_valid is produced, and all partial samples are discarded.

## Timing
- Let the last sample of a block be accepted at the end of cycle n, with the FSM IDLE.
  - busy is high in cycles n+1 through n+11.
  - SCALE is cycle n+1; BCD is cycles n+2 to n+10; DONE is cycle n+11.
  - temp_valid is high in cycle n+11 only, and the new temp_c, BCD digits and led are visible in that same cycle.
- Latency from the final sample to temp_valid is 11 cycles.
- A sample_valid in the same cycle as temp_valid is accepted normally into the next block.
- The minimum block spacing with no overrun is 12 cycles between block-completing samples.
- The SPI reader produces one sample per frame, which is far slower than this, so overrun flags a fault only.

## Test plan
- **Basic conversion.** rst, then 8 samples of 100 spaced 20 cycles apart → temp_valid exactly 11 cycles after the 8th, temp_c = 128, BCD 1/2/8, led = 1, overrun = 0.
- **Full scale and truncation.** 8 samples of 255 → temp_c = 328, BCD 3/2/8. Then seven 0s and one 7 → avg 0, temp_c = 0, BCD 0/0/0, led cleared.
- **Hysteresis sequence**, each a block of 8 identical samples:
  - 31 → temp 39, led stays 0
  - 32 → temp 41, led = 1
  - 31 → temp 39, led holds 1
  - 29 → temp 37, led = 0
- **Overrun.** 24 samples of 100 on consecutive cycles:
  - the first block converts (temp_valid in cycle n+11);
  - the second block completes while busy and is dropped, overrun = 1;
  - the third block converts, giving exactly 2 temp_valid pulses;
  - overrun remains 1 until rst.
- **Reset mid-operation.** Assert rst during the BCD phase → no temp_valid, all outputs 0 on the next cycle. Then 8 samples of 24 → temp_c = 30, BCD 0/3/0, led = 0.
- **Partial block.** 5 samples then rst, then 8 samples of 50 → temp_c = 64 (the stale partial samples are not included).
